pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port ID_PCSrc  input  3  PC-source code from the control decoder for the instruction in ID: 000 seq, 001 branch (resolved in EX), 010 j/jal, 011 jr/jalr, 100 interrupt, 101 exception.
REQ-004 SHALL have port ID_RsData  input  32  forwarded rs value in ID, the jr/jalr target.
REQ-005 SHALL have port EX_BranchTaken  input  1  branch in EX resolved taken.
REQ-006 SHALL have port EX_BranchTarget  input  32  branch target computed in EX.
REQ-007 SHALL have port Stall  input  1  load-use stall request from the hazard unit.
REQ-008 SHALL have port IMemData  input  32  instruction word; combinational read of IMemAddr.
REQ-009 SHALL have port IMemAddr  output  32  fetch address, equal to PC register.
REQ-010 SHALL have port IF_ID_Instr  output  32  registered instruction to ID.
REQ-011 SHALL have port IF_ID_PCPlus4  output  32  registered PC+4 of that instruction.
REQ-012 SHALL have port IF_ID_Valid  output  1  1 = real instruction, 0 = bubble.
REQ-013 SHALL have port ker  output  1  kernel-mode flag, equal to PC[31]; feeds interrupt masking in control.
REQ-014 SHALL have port FlushIDEX  output  1  combinational; asserted when EX_BranchTaken=1, so the ID/EX register bubbles.

Function
REQ-015 SHALL compute PCPlus4 = {PC[31], PC[30:0]+4}: bit 31 preserved, and the lower 31 bits wrap modulo 2^31.
REQ-016 SHALL compute JumpTarget = {IF_ID_PCPlus4[31:28], IF_ID_Instr[25:0], 2'b00}.
REQ-017 SHALL use JRTarget = {ID_RsData[31:2], 2'b00}; jr is the only path that may clear PC[31].
REQ-018 SHALL use interrupt vector 0x80000004 and exception vector 0x80000008.
REQ-019 SHALL apply, each cycle, the first matching rule: (a) EX_BranchTaken: PC<=EX_BranchTarget, IF/ID<=bubble; (b) Stall: PC and IF/ID hold; (c) ID_PCSrc in {010,011,100,101} with IF_ID_Valid=1: PC<=selected target, IF/ID<=bubble; (d) otherwise PC<=PCPlus4, IF/ID<={IMemData, PCPlus4, 1}.
REQ-020 SHALL treat ID_PCSrc 000 and 001 identically (sequential fetch), because branches redirect only via EX_BranchTaken.
REQ-021 SHALL define a bubble as IF_ID_Instr=0x00000000 (nop), IF_ID_PCPlus4=0, IF_ID_Valid=0.
REQ-022 SHALL ignore ID_PCSrc whenever IF_ID_Valid=0, so a bubble never redirects.
REQ-023 SHALL ignore Stall when EX_BranchTaken=1 in the same cycle; the older branch wins.
REQ-024 SHALL hold IF/ID and PC for every cycle Stall remains high; an ID redirect pending under a stall takes effect in the first cycle Stall is low.
REQ-025 SHALL apply a one-cycle redirect latency: the target appears on IMemAddr the cycle after the redirect condition.
REQ-026 SHALL drive ker combinationally from PC[31], with no extra register.
REQ-027 SHALL contain no other state beyond PC (32 bits) and IF/ID (65 bits).

Reset
REQ-028 SHALL, while reset=1, asynchronously set PC=0x80000000 (so ker=1) and IF/ID to a bubble.
REQ-029 SHALL begin fetching from 0x80000000 on the first rising clk after reset deasserts; reset mid-redirect or mid-stall discards the pending action.

Verification
REQ-030 SHALL verify reset: assert reset mid-run -> IMemAddr=0x80000000, ker=1, IF_ID_Valid=0, IF_ID_Instr=0 immediately (no clock edge needed).
REQ-031 SHALL verify sequential fetch and wrap: PC=0x7FFFFFFC -> next PC 0x00000000; PC=0xFFFFFFFC -> next PC 0x80000000.
REQ-032 SHALL verify jump: IF_ID_Instr=0x08100004, IF_ID_PCPlus4=0x00400014, ID_PCSrc=010 -> next IMemAddr=0x00400010, IF_ID_Valid=0.
REQ-033 SHALL verify branch over stall: Stall=1 and EX_BranchTaken=1, EX_BranchTarget=0x00400040 -> next PC 0x00400040, FlushIDEX=1, IF/ID bubble.
REQ-034 SHALL verify interrupt under stall: ID_PCSrc=100 with Stall=1 for 2 cycles -> PC held for 2 cycles, then PC=0x80000004 with ker=1.
REQ-035 SHALL verify kernel exit and bubble: jr with ID_RsData=0x00400003 -> PC=0x00400000 and ker=0; ID_PCSrc=101 while IF_ID_Valid=0 -> no redirect.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: redirect/stall inputs from ID/EX/hazard logic, the
// instruction-memory port, and the IF/ID register outputs toward decode.
interface pc_fetch_if;
    logic [2:0]  ID_PCSrc;
    logic [31:0] ID_RsData;
    logic        EX_BranchTaken;
    logic [31:0] EX_BranchTarget;
    logic        Stall;
    logic [31:0] IMemData;
    logic [31:0] IMemAddr;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        ker;
    logic        FlushIDEX;

    // Surrounding pipeline / memory side
    modport master (
        output ID_PCSrc, ID_RsData, EX_BranchTaken, EX_BranchTarget, Stall, IMemData,
        input  IMemAddr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, ker, FlushIDEX
    );

    // Fetch stage side
    modport slave (
        input  ID_PCSrc, ID_RsData, EX_BranchTaken, EX_BranchTarget, Stall, IMemData,
        output IMemAddr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, ker, FlushIDEX
    );
endinterface

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID
// pipeline register. Priority: EX branch > stall > ID redirect > sequential.
module pc_fetch (
    input logic        clk,
    input logic        reset,
    pc_fetch_if.slave  bus
);
    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] INTR_VEC  = 32'h8000_0004;
    localparam logic [31:0] EXCP_VEC  = 32'h8000_0008;

    localparam logic [2:0] SRC_J    = 3'b010;
    localparam logic [2:0] SRC_JR   = 3'b011;
    localparam logic [2:0] SRC_INTR = 3'b100;
    localparam logic [2:0] SRC_EXCP = 3'b101;

    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q,  pcp4_d;
    logic        valid_q, valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] jump_tgt;
    logic [31:0] jr_tgt;
    logic        id_redirect;
    logic [31:0] id_tgt;

    // Bit 31 is the kernel flag and survives sequential fetch; only the low
    // 31 bits advance (and wrap), so user code never falls into kernel space.
    assign pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};
    assign jump_tgt = {pcp4_q[31:28], instr_q[25:0], 2'b00};
    // Masking (not slicing) keeps the whole rs word in use; jr is the one
    // path that can leave kernel mode.
    assign jr_tgt   = bus.ID_RsData & 32'hFFFF_FFFC;

    // ID-stage redirect only counts for a real instruction, never a bubble
    assign id_redirect = valid_q && (bus.ID_PCSrc inside {SRC_J, SRC_JR, SRC_INTR, SRC_EXCP});

    // Select the ID-stage redirect target
    always_comb begin
        id_tgt = jump_tgt;
        unique case (bus.ID_PCSrc)
            SRC_JR:   id_tgt = jr_tgt;
            SRC_INTR: id_tgt = INTR_VEC;
            SRC_EXCP: id_tgt = EXCP_VEC;
            default:  id_tgt = jump_tgt;
        endcase
    end

    // Next-state for PC and IF/ID, first matching rule wins
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        if (bus.EX_BranchTaken) begin
            // Older branch overrides any stall or ID redirect
            pc_d    = bus.EX_BranchTarget;
            instr_d = '0;
            pcp4_d  = '0;
            valid_d = 1'b0;
        end else if (bus.Stall) begin
            // Hold everything; a pending ID redirect stays visible in IF/ID
        end else if (id_redirect) begin
            pc_d    = id_tgt;
            instr_d = '0;
            pcp4_d  = '0;
            valid_d = 1'b0;
        end else begin
            pc_d    = pc_plus4;
            instr_d = bus.IMemData;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
        end
    end

    // PC and IF/ID registers; reset fetches from the kernel boot address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    assign bus.IMemAddr      = pc_q;
    assign bus.ker           = pc_q[31];
    assign bus.IF_ID_Instr   = instr_q;
    assign bus.IF_ID_PCPlus4 = pcp4_q;
    assign bus.IF_ID_Valid   = valid_q;
    assign bus.FlushIDEX     = bus.EX_BranchTaken;
endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed vectors, a behavioural next-PC model checked
// every cycle, and literal expectations at the interesting points.
module tb_pc_fetch;
    logic clk   = 1'b0;
    logic reset = 1'b0;

    pc_fetch_if bus ();

    pc_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: one planted jump word, everything else a hash of the address
    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0040_0010) return 32'h0810_0004;
        return a ^ 32'h1357_9BDF;
    endfunction

    assign bus.IMemData = imem(bus.IMemAddr);

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_instr, m_pcp4;
    logic        m_valid;

    function automatic logic [31:0] seq_next(input logic [31:0] pc);
        return (pc & 32'h8000_0000) | ((pc + 32'd4) & 32'h7FFF_FFFF);
    endfunction

    function automatic logic [31:0] id_target(input logic [2:0] src, input logic [31:0] instr,
                                              input logic [31:0] pcp4, input logic [31:0] rs);
        case (src)
            3'd2:    return (pcp4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 4);
            3'd3:    return rs - (rs % 4);
            3'd4:    return 32'h8000_0004;
            default: return 32'h8000_0008;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc    <= 32'h8000_0000;
            m_instr <= 32'h0;
            m_pcp4  <= 32'h0;
            m_valid <= 1'b0;
        end else if (bus.EX_BranchTaken) begin
            m_pc    <= bus.EX_BranchTarget;
            m_instr <= 32'h0;
            m_pcp4  <= 32'h0;
            m_valid <= 1'b0;
        end else if (bus.Stall) begin
            m_pc    <= m_pc;
        end else if (m_valid && bus.ID_PCSrc >= 3'd2 && bus.ID_PCSrc <= 3'd5) begin
            m_pc    <= id_target(bus.ID_PCSrc, m_instr, m_pcp4, bus.ID_RsData);
            m_instr <= 32'h0;
            m_pcp4  <= 32'h0;
            m_valid <= 1'b0;
        end else begin
            m_pc    <= seq_next(m_pc);
            m_instr <= imem(m_pc);
            m_pcp4  <= seq_next(m_pc);
            m_valid <= 1'b1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            chk("pc",    bus.IMemAddr,             m_pc);
            chk("ker",   {31'b0, bus.ker},         {31'b0, m_pc[31]});
            chk("instr", bus.IF_ID_Instr,          m_instr);
            chk("pcp4",  bus.IF_ID_PCPlus4,        m_pcp4);
            chk("valid", {31'b0, bus.IF_ID_Valid}, {31'b0, m_valid});
            chk("flush", {31'b0, bus.FlushIDEX},   {31'b0, bus.EX_BranchTaken});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [2:0] src, input logic [31:0] rs, input logic bt,
                         input logic [31:0] tgt, input logic st);
        bus.ID_PCSrc        = src;
        bus.ID_RsData       = rs;
        bus.EX_BranchTaken  = bt;
        bus.EX_BranchTarget = tgt;
        bus.Stall           = st;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cyc(input logic [2:0] src, input logic [31:0] rs, input logic bt,
                       input logic [31:0] tgt, input logic st);
        drive(src, rs, bt, tgt, st);
        tick();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"},    bus.IMemAddr,             32'h8000_0000);
        chk({tag, "_ker"},   {31'b0, bus.ker},         32'h1);
        chk({tag, "_valid"}, {31'b0, bus.IF_ID_Valid}, 32'h0);
        chk({tag, "_instr"}, bus.IF_ID_Instr,          32'h0);
        chk({tag, "_pcp4"},  bus.IF_ID_PCPlus4,        32'h0);
    endtask

    initial begin
        drive(3'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1 reset = 1'b1;
        #2 chk_reset_state("rst0");
        @(posedge clk);
        #2 reset = 1'b0;

        // Sequential fetch from the boot address
        cyc(3'd0, 0, 0, 0, 0);
        cyc(3'd0, 0, 0, 0, 0);
        chk("seq_pc",   bus.IMemAddr,      32'h8000_0008);
        chk("seq_pcp4", bus.IF_ID_PCPlus4, 32'h8000_0008);
        chk("seq_ins",  bus.IF_ID_Instr,   32'h8000_0004 ^ 32'h1357_9BDF);

        // Low-half wrap: 0x7FFFFFFC -> 0x00000000
        cyc(3'd0, 0, 1, 32'h7FFF_FFFC, 0);
        cyc(3'd0, 0, 0, 0, 0);
        chk("wrap_lo", bus.IMemAddr, 32'h0000_0000);
        chk("wrap_lo_ker", {31'b0, bus.ker}, 32'h0);

        // Kernel wrap: 0xFFFFFFFC -> 0x80000000
        cyc(3'd0, 0, 1, 32'hFFFF_FFFC, 0);
        cyc(3'd0, 0, 0, 0, 0);
        chk("wrap_hi", bus.IMemAddr, 32'h8000_0000);

        // Jump: fetch 0x08100004 at 0x00400010, then j in ID
        cyc(3'd0, 0, 1, 32'h0040_0010, 0);
        cyc(3'd0, 0, 0, 0, 0);
        chk("j_ins",  bus.IF_ID_Instr,   32'h0810_0004);
        chk("j_pcp4", bus.IF_ID_PCPlus4, 32'h0040_0014);
        cyc(3'd2, 0, 0, 0, 0);
        chk("j_pc",    bus.IMemAddr,             32'h0040_0010);
        chk("j_valid", {31'b0, bus.IF_ID_Valid}, 32'h0);

        // Branch beats stall
        cyc(3'd0, 0, 0, 0, 0);
        drive(3'd0, 0, 1, 32'h0040_0040, 1);
        #1 chk("br_flush", {31'b0, bus.FlushIDEX}, 32'h1);
        tick();
        chk("br_pc",    bus.IMemAddr,             32'h0040_0040);
        chk("br_valid", {31'b0, bus.IF_ID_Valid}, 32'h0);
        chk("br_instr", bus.IF_ID_Instr,          32'h0);

        // Interrupt pending under a 2-cycle stall
        cyc(3'd0, 0, 0, 0, 0);
        cyc(3'd4, 0, 0, 0, 1);
        chk("int_hold1", bus.IMemAddr, 32'h0040_0044);
        cyc(3'd4, 0, 0, 0, 1);
        chk("int_hold2", bus.IMemAddr, 32'h0040_0044);
        cyc(3'd4, 0, 0, 0, 0);
        chk("int_pc",  bus.IMemAddr,     32'h8000_0004);
        chk("int_ker", {31'b0, bus.ker}, 32'h1);

        // jr leaves kernel mode; exception code against a bubble is ignored
        cyc(3'd0, 0, 0, 0, 0);
        cyc(3'd3, 32'h0040_0003, 0, 0, 0);
        chk("jr_pc",  bus.IMemAddr,     32'h0040_0000);
        chk("jr_ker", {31'b0, bus.ker}, 32'h0);
        cyc(3'd5, 0, 0, 0, 0);
        chk("bub_pc",    bus.IMemAddr,             32'h0040_0004);
        chk("bub_valid", {31'b0, bus.IF_ID_Valid}, 32'h1);

        // Exception taken from a valid instruction
        cyc(3'd5, 0, 0, 0, 0);
        chk("exc_pc", bus.IMemAddr, 32'h8000_0008);

        // Reset mid-stall with a pending redirect: discarded immediately
        cyc(3'd0, 0, 0, 0, 0);
        cyc(3'd5, 0, 0, 0, 1);
        #1 reset = 1'b1;
        #1 chk_reset_state("rst1");
        @(posedge clk);
        #2 reset = 1'b0;
        cyc(3'd0, 0, 0, 0, 0);
        chk("post_rst_pc",   bus.IMemAddr,      32'h8000_0004);
        chk("post_rst_pcp4", bus.IF_ID_PCPlus4, 32'h8000_0004);
        cyc(3'd0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
